alu_issue: RTL and testbench
============================

# alu_issue

Sequential issue/capture stage sitting directly upstream of the combinational `alu`. It accepts one operation at a time through a valid/ready request handshake and registers the operands and opcode onto the `alu` input ports. After a configurable settle time it captures the `alu` result and returns it through a valid/ready response handshake. It also keeps a count of completed operations.

## Interface
- `SETTLE_CYCLES`, default 1: cycles between driving the `alu` inputs and capturing its result. Legal range is 1..15.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-low reset.
- `REQ_VALID`  in  1  request present.
- `REQ_READY`  out  1  stage can accept a request this cycle.
- `REQ_OP1`  in  `DATA_WIDTH` (32)  operand 1.
- `REQ_OP2`  in  `DATA_WIDTH` (32)  operand 2.
- `REQ_OPRN`  in  `ALU_OPRN_WIDTH` (6)  operation code.
- `ALU_OP1`  out  32  registered operand 1 to `alu.op1`.
- `ALU_OP2`  out  32  registered operand 2 to `alu.op2`.
- `ALU_OPRN`  out  6  registered opcode to `alu.oprn`.
- `ALU_RESULT`  in  32  from `alu.result`.
- `RSP_VALID`  out  1  response present.
- `RSP_READY`  in  1  consumer accepts the response.
- `RSP_RESULT`  out  32  captured result.
- `RSP_ERR`  out  1  illegal opcode flag (see Configuration).
- `CNT_DONE`  out  16  number of completed responses.

## Operation
- Opcodes:
  - 0x01 add, 0x02 sub, 0x03 mul.
  - 0x04 shift right, 0x05 shift left.
  - 0x06 and, 0x07 or, 0x08 nor.
  - 0x09 set-less-than (unsigned).
  - Arithmetic is done by `alu`; this block never modifies data.
- States are IDLE, WAIT and RESP.
- IDLE:
  - `REQ_READY`=1.
  - On `REQ_VALID`=1: load `ALU_OP1/OP2/OPRN` from `REQ_*`, load the settle counter with `SETTLE_CYCLES`-1, go to WAIT.
- WAIT:
  - If the counter is nonzero, decrement it.
  - If the counter is 0, capture `ALU_RESULT` into `RSP_RESULT`, set `RSP_VALID`=1, go to RESP.
  - `REQ_READY`=0.
- RESP:
  - `RSP_VALID`=1; `RSP_RESULT` and `RSP_ERR` are held stable.
  - On an edge with `RSP_READY`=1: `CNT_DONE` increments and `RSP_VALID` drops.
    - If `REQ_VALID`=1 on the same edge, the new request is accepted (same action as IDLE) and the state goes to WAIT.
    - Otherwise the state goes to IDLE.
- `REQ_READY` = (state==IDLE) | (state==RESP & `RSP_READY`). This is a combinational path from `RSP_READY` to `REQ_READY` and is intended.
- `ALU_*` change only on request acceptance. They hold their last values in IDLE and RESP.
- `CNT_DONE` is 16-bit and wraps 0xFFFF→0x0000 without saturating.

## Timing
- Reset: on a `RST`=0 edge:
  - State=IDLE.
  - `ALU_OP1`=`ALU_OP2`=0, `ALU_OPRN`=0.
  - `RSP_RESULT`=0, `RSP_VALID`=0, `RSP_ERR`=0, `CNT_DONE`=0.
  - `REQ_READY`=1 from the first cycle after reset.
- Reset mid-operation (WAIT or RESP) abandons the operation. No response is produced and `CNT_DONE` is not incremented.
- Latency: the request is accepted at edge E0. `RSP_VALID` is high after edge E0+`SETTLE_CYCLES` and stays high until the edge where `RSP_READY`=1.
- Throughput with `RSP_READY` held at 1: one operation every `SETTLE_CYCLES`+1 cycles, because accept and retire share an edge.
- `REQ_*` are sampled only at the acceptance edge. Changes at any other time are ignored.

## Configuration
- Macro: `ALU_ISSUE_OPRN_CHECK_EN`.
- Defined: an accepted opcode outside 0x01..0x09 is not driven to `alu`.
  - `ALU_*` keep their previous values.
  - The state goes straight to RESP on the next edge with `RSP_RESULT`=0 and `RSP_ERR`=1.
  - Response latency is 1 cycle regardless of `SETTLE_CYCLES`.
  - `RSP_ERR` is cleared on the next accepted legal request.
- Undefined: every opcode is forwarded to `alu` and its result is captured unchanged. `RSP_ERR` is tied to 0.

## Test plan
- Basic add, `SETTLE_CYCLES`=1, `RSP_READY`=1: request 15 + 3 (0x01) → `RSP_VALID` high exactly one cycle after acceptance with `RSP_RESULT`=18; `CNT_DONE`=1.
- Backpressure: NOR of 6 and 9 (0x08) with `RSP_READY`=0 for 5 cycles → `RSP_RESULT`=0xFFFFFFF0 stable for all 5 cycles; `REQ_READY`=0 throughout; retires on the first `RSP_READY`=1 edge.
- Back-to-back, `SETTLE_CYCLES`=3: stream 2 * 7 then 4 >> 2 then 3 << 3 with `RSP_READY`=1 → results 14, 1, 24, each retire edge also accepting the next request; 4-cycle spacing.
- Reset mid-WAIT (`SETTLE_CYCLES`=4): assert `RST`=0 two cycles after accepting 5 - 5 → all outputs at their reset values; no response; `CNT_DONE`=0; `REQ_READY`=1.
- Opcode check, macro defined: `REQ_OPRN`=0x0A → one cycle later `RSP_VALID`=1, `RSP_ERR`=1, `RSP_RESULT`=0, `ALU_OPRN` unchanged. A following 4 < 5 (0x09) → result 1 with `RSP_ERR`=0.
- Counter wrap: preload by 65535 completed responses, then complete one more → `CNT_DONE`=0x0000.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: issue/capture stage in front of the combinational alu.
// Accepts one request at a time, registers operands/opcode onto the alu
// inputs, waits SETTLE_CYCLES, captures the alu result and hands it out
// through a valid/ready response port. Counts completed responses.
// Optional feature macro: ALU_ISSUE_OPRN_CHECK_EN (illegal-opcode trap).
module alu_issue #(
    parameter int SETTLE_CYCLES  = 1,   // legal range 1..15
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_OPRN_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      REQ_VALID,
    output logic                      REQ_READY,
    input  logic [DATA_WIDTH-1:0]     REQ_OP1,
    input  logic [DATA_WIDTH-1:0]     REQ_OP2,
    input  logic [ALU_OPRN_WIDTH-1:0] REQ_OPRN,
    output logic [DATA_WIDTH-1:0]     ALU_OP1,
    output logic [DATA_WIDTH-1:0]     ALU_OP2,
    output logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN,
    input  logic [DATA_WIDTH-1:0]     ALU_RESULT,
    output logic                      RSP_VALID,
    input  logic                      RSP_READY,
    output logic [DATA_WIDTH-1:0]     RSP_RESULT,
    output logic                      RSP_ERR,
    output logic [15:0]               CNT_DONE
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Counter preload: WAIT lasts SETTLE_CYCLES edges including the capture edge.
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  settle_cnt;
    logic [15:0] cnt_q;
    logic        accept;
    logic        illegal;

    assign accept   = REQ_VALID & REQ_READY;
    assign CNT_DONE = cnt_q;

`ifdef ALU_ISSUE_OPRN_CHECK_EN
    // Only opcodes 0x01..0x09 are forwarded to the alu.
    assign illegal = (REQ_OPRN == '0) || (REQ_OPRN > ALU_OPRN_WIDTH'(9));
`else
    assign illegal = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; an illegal opcode skips WAIT and answers on the next edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = illegal ? RESP : WAIT;
            WAIT: if (settle_cnt == '0) state_nxt = RESP;
            RESP: begin
                if (RSP_READY) begin
                    if (REQ_VALID) state_nxt = illegal ? RESP : WAIT;
                    else           state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; REQ_READY sees RSP_READY combinationally so a retire
    // edge can also accept the next request.
    always_comb begin
        REQ_READY = (state == IDLE) || ((state == RESP) && RSP_READY);
        RSP_VALID = (state == RESP);
    end

    // Datapath: alu input registers, settle counter, result capture, done count.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ALU_OP1    <= '0;
            ALU_OP2    <= '0;
            ALU_OPRN   <= '0;
            settle_cnt <= '0;
            RSP_RESULT <= '0;
            cnt_q      <= '0;
        end else begin
            if (accept && !illegal) begin
                ALU_OP1    <= REQ_OP1;
                ALU_OP2    <= REQ_OP2;
                ALU_OPRN   <= REQ_OPRN;
                settle_cnt <= SETTLE_M1;
            end else if ((state == WAIT) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if ((state == WAIT) && (settle_cnt == '0))
                RSP_RESULT <= ALU_RESULT;
            else if (accept && illegal)
                RSP_RESULT <= '0;

            if ((state == RESP) && RSP_READY)
                cnt_q <= cnt_q + 16'd1;
        end
    end

`ifdef ALU_ISSUE_OPRN_CHECK_EN
    // Error flag follows the most recently accepted request.
    always_ff @(posedge CLK) begin
        if (!RST)        RSP_ERR <= 1'b0;
        else if (accept) RSP_ERR <= illegal;
    end
`else
    assign RSP_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: three instances (SETTLE_CYCLES 1, 3, 4),
// each fed by a small behavioural alu model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst        [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [31:0] req_op1    [3];
    logic [31:0] req_op2    [3];
    logic [5:0]  req_oprn   [3];
    logic [31:0] alu_op1    [3];
    logic [31:0] alu_op2    [3];
    logic [5:0]  alu_oprn   [3];
    logic [31:0] alu_res    [3];
    logic        rsp_valid  [3];
    logic        rsp_ready  [3];
    logic [31:0] rsp_result [3];
    logic        rsp_err    [3];
    logic [15:0] cnt_done   [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] op);
        case (op)
            6'h01: return a + b;
            6'h02: return a - b;
            6'h03: return a * b;
            6'h04: return a >> b;
            6'h05: return a << b;
            6'h06: return a & b;
            6'h07: return a | b;
            6'h08: return ~(a | b);
            6'h09: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_alu
        assign alu_res[g] = alu_f(alu_op1[g], alu_op2[g], alu_oprn[g]);
    end

    alu_issue #(.SETTLE_CYCLES(1)) u_dut1 (
        .CLK(clk), .RST(rst[0]), .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
        .REQ_OP1(req_op1[0]), .REQ_OP2(req_op2[0]), .REQ_OPRN(req_oprn[0]),
        .ALU_OP1(alu_op1[0]), .ALU_OP2(alu_op2[0]), .ALU_OPRN(alu_oprn[0]),
        .ALU_RESULT(alu_res[0]), .RSP_VALID(rsp_valid[0]), .RSP_READY(rsp_ready[0]),
        .RSP_RESULT(rsp_result[0]), .RSP_ERR(rsp_err[0]), .CNT_DONE(cnt_done[0]));

    alu_issue #(.SETTLE_CYCLES(3)) u_dut3 (
        .CLK(clk), .RST(rst[1]), .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
        .REQ_OP1(req_op1[1]), .REQ_OP2(req_op2[1]), .REQ_OPRN(req_oprn[1]),
        .ALU_OP1(alu_op1[1]), .ALU_OP2(alu_op2[1]), .ALU_OPRN(alu_oprn[1]),
        .ALU_RESULT(alu_res[1]), .RSP_VALID(rsp_valid[1]), .RSP_READY(rsp_ready[1]),
        .RSP_RESULT(rsp_result[1]), .RSP_ERR(rsp_err[1]), .CNT_DONE(cnt_done[1]));

    alu_issue #(.SETTLE_CYCLES(4)) u_dut4 (
        .CLK(clk), .RST(rst[2]), .REQ_VALID(req_valid[2]), .REQ_READY(req_ready[2]),
        .REQ_OP1(req_op1[2]), .REQ_OP2(req_op2[2]), .REQ_OPRN(req_oprn[2]),
        .ALU_OP1(alu_op1[2]), .ALU_OP2(alu_op2[2]), .ALU_OPRN(alu_oprn[2]),
        .ALU_RESULT(alu_res[2]), .RSP_VALID(rsp_valid[2]), .RSP_READY(rsp_ready[2]),
        .RSP_RESULT(rsp_result[2]), .RSP_ERR(rsp_err[2]), .CNT_DONE(cnt_done[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] op);
        req_valid[d] = v;
        req_op1[d]   = a;
        req_op2[d]   = b;
        req_oprn[d]  = op;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0;
            rsp_ready[i] = 1'b0;
            drive(i, 1'b0, 32'd0, 32'd0, 6'd0);
        end
        tick(2);

        // Reset values
        chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_alu_op1",   alu_op1[0], 32'd0);
        chk("rst_alu_oprn",  32'(alu_oprn[0]), 32'd0);
        chk("rst_result",    rsp_result[0], 32'd0);
        chk("rst_err",       32'(rsp_err[0]), 32'd0);
        chk("rst_cnt",       32'(cnt_done[0]), 32'd0);
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        tick();

        // Basic add, SETTLE=1
        rsp_ready[0] = 1'b1;
        drive(0, 1'b1, 32'd15, 32'd3, 6'h01);
        tick();
        drive(0, 1'b0, 32'd0, 32'd0, 6'h00);
        chk("add_alu_op1",    alu_op1[0], 32'd15);
        chk("add_wait_valid", 32'(rsp_valid[0]), 32'd0);
        chk("add_wait_ready", 32'(req_ready[0]), 32'd0);
        tick();
        chk("add_rsp_valid",  32'(rsp_valid[0]), 32'd1);
        chk("add_result",     rsp_result[0], 32'd18);
        tick();
        chk("add_retired",    32'(rsp_valid[0]), 32'd0);
        chk("add_cnt",        32'(cnt_done[0]), 32'd1);
        chk("add_idle_ready", 32'(req_ready[0]), 32'd1);

        // Backpressure: NOR held for 5 cycles; late REQ_* changes ignored
        rsp_ready[0] = 1'b0;
        drive(0, 1'b1, 32'd6, 32'd9, 6'h08);
        tick();
        drive(0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 6'h01);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",  32'(rsp_valid[0]), 32'd1);
            chk("bp_result", rsp_result[0], 32'hFFFF_FFF0);
            chk("bp_ready",  32'(req_ready[0]), 32'd0);
            tick();
        end
        chk("bp_alu_op1_held", alu_op1[0], 32'd6);
        rsp_ready[0] = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(req_ready[0]), 32'd1);
        tick();
        chk("bp_retired", 32'(rsp_valid[0]), 32'd0);
        chk("bp_cnt",     32'(cnt_done[0]), 32'd2);

        // Back-to-back, SETTLE=3: accepts at E0, E4, E8
        rsp_ready[1] = 1'b1;
        drive(1, 1'b1, 32'd2, 32'd7, 6'h03);
        tick();
        drive(1, 1'b1, 32'd4, 32'd2, 6'h04);
        tick(2);
        chk("b2b_wait_valid", 32'(rsp_valid[1]), 32'd0);
        tick();
        chk("b2b_mul_valid",  32'(rsp_valid[1]), 32'd1);
        chk("b2b_mul",        rsp_result[1], 32'd14);
        chk("b2b_ready_resp", 32'(req_ready[1]), 32'd1);
        tick();
        chk("b2b_acc2_op1",   alu_op1[1], 32'd4);
        chk("b2b_acc2_oprn",  32'(alu_oprn[1]), 32'h04);
        chk("b2b_cnt1",       32'(cnt_done[1]), 32'd1);
        drive(1, 1'b1, 32'd3, 32'd3, 6'h05);
        tick(2);
        chk("b2b_shr_early",  32'(rsp_valid[1]), 32'd0);
        tick();
        chk("b2b_shr",        rsp_result[1], 32'd1);
        tick();
        drive(1, 1'b0, 32'd0, 32'd0, 6'h00);
        chk("b2b_cnt2",       32'(cnt_done[1]), 32'd2);
        chk("b2b_acc3_oprn",  32'(alu_oprn[1]), 32'h05);
        tick(3);
        chk("b2b_shl_valid",  32'(rsp_valid[1]), 32'd1);
        chk("b2b_shl",        rsp_result[1], 32'd24);
        tick();
        chk("b2b_cnt3",       32'(cnt_done[1]), 32'd3);
        chk("b2b_idle",       32'(rsp_valid[1]), 32'd0);

        // Reset mid-WAIT, SETTLE=4
        rsp_ready[2] = 1'b1;
        drive(2, 1'b1, 32'd5, 32'd5, 6'h02);
        tick();
        drive(2, 1'b0, 32'd0, 32'd0, 6'h00);
        chk("mid_wait_ready", 32'(req_ready[2]), 32'd0);
        tick(2);
        rst[2] = 1'b0;
        tick();
        rst[2] = 1'b1;
        chk("mid_rst_valid",  32'(rsp_valid[2]), 32'd0);
        chk("mid_rst_op1",    alu_op1[2], 32'd0);
        chk("mid_rst_oprn",   32'(alu_oprn[2]), 32'd0);
        chk("mid_rst_result", rsp_result[2], 32'd0);
        chk("mid_rst_ready",  32'(req_ready[2]), 32'd1);
        tick(5);
        chk("mid_no_rsp",     32'(rsp_valid[2]), 32'd0);
        chk("mid_cnt",        32'(cnt_done[2]), 32'd0);

        // Out-of-range opcode 0x0A, then 4 < 5
        rsp_ready[0] = 1'b0;
        drive(0, 1'b1, 32'd1, 32'd2, 6'h0A);
        tick();
`ifdef ALU_ISSUE_OPRN_CHECK_EN
        chk("ill_valid",      32'(rsp_valid[0]), 32'd1);
        chk("ill_err",        32'(rsp_err[0]), 32'd1);
        chk("ill_result",     rsp_result[0], 32'd0);
        chk("ill_oprn_held",  32'(alu_oprn[0]), 32'h08);
        rsp_ready[0] = 1'b1;
        drive(0, 1'b1, 32'd4, 32'd5, 6'h09);
        tick();
        drive(0, 1'b0, 32'd0, 32'd0, 6'h00);
        chk("slt_oprn",       32'(alu_oprn[0]), 32'h09);
        chk("slt_wait",       32'(rsp_valid[0]), 32'd0);
        tick();
`else
        drive(0, 1'b0, 32'd0, 32'd0, 6'h00);
        chk("fwd_oprn",       32'(alu_oprn[0]), 32'h0A);
        chk("fwd_wait",       32'(rsp_valid[0]), 32'd0);
        tick();
        chk("fwd_valid",      32'(rsp_valid[0]), 32'd1);
        chk("fwd_err",        32'(rsp_err[0]), 32'd0);
        rsp_ready[0] = 1'b1;
        drive(0, 1'b1, 32'd4, 32'd5, 6'h09);
        tick();
        drive(0, 1'b0, 32'd0, 32'd0, 6'h00);
        chk("slt_oprn",       32'(alu_oprn[0]), 32'h09);
        tick();
`endif
        chk("slt_valid",      32'(rsp_valid[0]), 32'd1);
        chk("slt_result",     rsp_result[0], 32'd1);
        chk("slt_err",        32'(rsp_err[0]), 32'd0);
        tick();
        chk("slt_cnt",        32'(cnt_done[0]), 32'd4);

        // Counter wrap: preload near the top, then complete two operations
        force u_dut1.cnt_q = 16'hFFFE;
        #1;
        release u_dut1.cnt_q;
        chk("wrap_preload",   32'(cnt_done[0]), 32'h0000_FFFE);
        for (int k = 0; k < 2; k++) begin
            drive(0, 1'b1, 32'd1, 32'd1, 6'h01);
            tick();
            drive(0, 1'b0, 32'd0, 32'd0, 6'h00);
            tick(2);
            chk("wrap_cnt", 32'(cnt_done[0]), (k == 0) ? 32'h0000_FFFF : 32'h0000_0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
